// File: rtl/dlx_pkg.sv
// Shared DLX pipeline constants: opcode/function encodings,
// bubble field values and the load-opcode classifier.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] FN_NOP     = 6'h15;
  localparam logic [5:0] OP_LOAD_LO = 6'h20;
  localparam logic [5:0] OP_LOAD_HI = 6'h27;

  localparam logic [5:0] BUB_OP     = OP_RTYPE;
  localparam logic [5:0] BUB_FN     = FN_NOP;
  localparam logic       BUB_ALUSRC = 1'b0;

  function automatic logic is_load(input logic [5:0] op);
    return (op >= OP_LOAD_LO) && (op <= OP_LOAD_HI);
  endfunction

endpackage

// File: rtl/id_exe_stage_if.sv
// ID->EXE bundle: decoded ID fields, Hold/Flush controls,
// latched EXE fields, Stall and StallCount.
interface id_exe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 6,
  parameter int CNT_W  = 16
);

  logic              IDValid;
  logic [5:0]        IDOpCode;
  logic [5:0]        IDFunction;
  logic [REG_W-1:0]  IDRs1;
  logic [REG_W-1:0]  IDRs2;
  logic [REG_W-1:0]  IDRd;
  logic              IDUsesRs1;
  logic              IDUsesRs2;
  logic              IDALUSrc;
  logic [DATA_W-1:0] IDA;
  logic [DATA_W-1:0] IDB;
  logic [DATA_W-1:0] IDImm;
  logic              Hold;
  logic              Flush;

  logic [5:0]        EXEOpCode;
  logic [5:0]        EXEFunction;
  logic [REG_W-1:0]  EXERs1;
  logic [REG_W-1:0]  EXERs2;
  logic [REG_W-1:0]  EXERd;
  logic              EXEALUSrc;
  logic [DATA_W-1:0] EXEA;
  logic [DATA_W-1:0] EXEB;
  logic [DATA_W-1:0] EXEImm;
  logic              Stall;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output IDValid, IDOpCode, IDFunction,
    output IDRs1, IDRs2, IDRd,
    output IDUsesRs1, IDUsesRs2, IDALUSrc,
    output IDA, IDB, IDImm, Hold, Flush,
    input  EXEOpCode, EXEFunction,
    input  EXERs1, EXERs2, EXERd, EXEALUSrc,
    input  EXEA, EXEB, EXEImm,
    input  Stall, StallCount
  );

  modport slave (
    input  IDValid, IDOpCode, IDFunction,
    input  IDRs1, IDRs2, IDRd,
    input  IDUsesRs1, IDUsesRs2, IDALUSrc,
    input  IDA, IDB, IDImm, Hold, Flush,
    output EXEOpCode, EXEFunction,
    output EXERs1, EXERs2, EXERd, EXEALUSrc,
    output EXEA, EXEB, EXEImm,
    output Stall, StallCount
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detect: EXE holds a load whose Rd is read by ID.
// Ports: EXE opcode/Rd, ID valid/sources/uses -> detect.
module load_use_detect
  import dlx_pkg::*;
#(
  parameter int REG_W = 6
) (
  input  logic [5:0]       exe_op,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  output logic             detect
);

  logic hit1;
  logic hit2;

  // r0 is deliberately not special-cased
  assign hit1 = id_uses_rs1 && (id_rs1 == exe_rd);
  assign hit2 = id_uses_rs2 && (id_rs2 == exe_rd);

  assign detect = is_load(exe_op) && id_valid
                  && (hit1 || hit2);

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with load-use interlock and a
// saturating stall counter. Ports: Clk, Rst_n, slave bundle.
module id_exe_stage
  import dlx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic          Clk,
  input  logic          Rst_n,
  id_exe_stage_if.slave bus
);

  typedef struct packed {
    logic [5:0]        op;
    logic [5:0]        fn;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              alu_src;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
  } exe_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic exe_t bubble();
    exe_t b;
    b         = '0;
    b.op      = BUB_OP;
    b.fn      = BUB_FN;
    b.alu_src = BUB_ALUSRC;
    return b;
  endfunction

  exe_t             exe_q, exe_d, id_f;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             detect;

  load_use_detect #(.REG_W(REG_W)) u_detect (
    .exe_op      (exe_q.op),
    .exe_rd      (exe_q.rd),
    .id_valid    (bus.IDValid),
    .id_rs1      (bus.IDRs1),
    .id_rs2      (bus.IDRs2),
    .id_uses_rs1 (bus.IDUsesRs1),
    .id_uses_rs2 (bus.IDUsesRs2),
    .detect      (detect)
  );

  always_comb begin
    id_f         = '0;
    id_f.op      = bus.IDOpCode;
    id_f.fn      = bus.IDFunction;
    id_f.rs1     = bus.IDRs1;
    id_f.rs2     = bus.IDRs2;
    id_f.rd      = bus.IDRd;
    id_f.alu_src = bus.IDALUSrc;
    id_f.a       = bus.IDA;
    id_f.b       = bus.IDB;
    id_f.imm     = bus.IDImm;
  end

  // Ordered: Hold over Flush over detect over invalid ID
  always_comb begin
    exe_d = exe_q;
    cnt_d = cnt_q;
    priority case (1'b1)
      bus.Hold: ;
      bus.Flush: exe_d = bubble();
      detect: begin
        exe_d = bubble();
        if (cnt_q != CNT_MAX)
          cnt_d = cnt_q + CNT_ONE;
      end
      !bus.IDValid: exe_d = bubble();
      default: exe_d = id_f;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      exe_q <= bubble();
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      cnt_q <= cnt_d;
    end
  end

  // EXE is a bubble in reset, so detect (and Stall) is low
  assign bus.Stall = detect && !bus.Flush && !bus.Hold;
  assign bus.StallCount  = cnt_q;
  assign bus.EXEOpCode   = exe_q.op;
  assign bus.EXEFunction = exe_q.fn;
  assign bus.EXERs1      = exe_q.rs1;
  assign bus.EXERs2      = exe_q.rs2;
  assign bus.EXERd       = exe_q.rd;
  assign bus.EXEALUSrc   = exe_q.alu_src;
  assign bus.EXEA        = exe_q.a;
  assign bus.EXEB        = exe_q.b;
  assign bus.EXEImm      = exe_q.imm;

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed + random bench for id_exe_stage against a
// behavioural model of the ID/EXE register and interlock.
module tb_id_exe_stage;

  localparam int DW = 32;
  localparam int RW = 6;
  // Narrow counter so saturation is reachable quickly
  localparam int CW = 8;
  localparam logic [CW-1:0] CMAX = '1;

  typedef struct packed {
    logic [5:0]    op;
    logic [5:0]    fn;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          src;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  ex_t           m_ex;
  logic [CW-1:0] m_cnt;

  always #5 clk = ~clk;

  id_exe_stage_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) bus ();

  id_exe_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  function automatic ex_t bub();
    ex_t e;
    e    = '0;
    e.fn = 6'h15;
    return e;
  endfunction

  function automatic ex_t obs_ex();
    ex_t e;
    e.op  = bus.EXEOpCode;
    e.fn  = bus.EXEFunction;
    e.rs1 = bus.EXERs1;
    e.rs2 = bus.EXERs2;
    e.rd  = bus.EXERd;
    e.src = bus.EXEALUSrc;
    e.a   = bus.EXEA;
    e.b   = bus.EXEB;
    e.imm = bus.EXEImm;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_id(
    input logic v, input logic [5:0] op, input logic [5:0] fn,
    input logic [RW-1:0] r1, input logic [RW-1:0] r2,
    input logic [RW-1:0] rd,
    input logic u1, input logic u2, input logic src,
    input logic [DW-1:0] a, input logic [DW-1:0] b,
    input logic [DW-1:0] imm, input logic h, input logic f);
    bus.IDValid    = v;
    bus.IDOpCode   = op;
    bus.IDFunction = fn;
    bus.IDRs1      = r1;
    bus.IDRs2      = r2;
    bus.IDRd       = rd;
    bus.IDUsesRs1  = u1;
    bus.IDUsesRs2  = u2;
    bus.IDALUSrc   = src;
    bus.IDA        = a;
    bus.IDB        = b;
    bus.IDImm      = imm;
    bus.Hold       = h;
    bus.Flush      = f;
  endtask

  // One cycle: check Stall, advance model, clock, check outputs
  task automatic tick();
    logic det;
    logic ld;
    ex_t  cap;
    #1;
    ld  = (m_ex.op >= 6'h20) && (m_ex.op <= 6'h27);
    det = ld && bus.IDValid &&
          ((bus.IDUsesRs1 && bus.IDRs1 == m_ex.rd) ||
           (bus.IDUsesRs2 && bus.IDRs2 == m_ex.rd));
    chk("stall", bus.Stall, det && !bus.Flush && !bus.Hold);
    cap = '{bus.IDOpCode, bus.IDFunction, bus.IDRs1,
            bus.IDRs2, bus.IDRd, bus.IDALUSrc,
            bus.IDA, bus.IDB, bus.IDImm};
    if (bus.Hold) begin
    end else if (bus.Flush) begin
      m_ex = bub();
    end else if (det) begin
      m_ex = bub();
      if (m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
    end else if (!bus.IDValid) begin
      m_ex = bub();
    end else begin
      m_ex = cap;
    end
    @(posedge clk);
    #1;
    chk("exe", obs_ex(), m_ex);
    chk("count", bus.StallCount, m_cnt);
  endtask

  task automatic load(input logic [RW-1:0] rd);
    set_id(1'b1, 6'h23, 6'h00, 6'd1, 6'd0, rd, 1'b1, 1'b0,
           1'b1, 32'h100, 32'h0, 32'h4, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    logic [CW-1:0] saved;
    logic [5:0]    rop;
    set_id(1'b1, 6'h08, 6'h00, 6'd1, 6'd2, 6'd3, 1'b1, 1'b0,
           1'b1, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
    m_ex  = bub();
    m_cnt = '0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_exe", obs_ex(), bub());
    chk("rst_cnt", bus.StallCount, 8'd0);
    chk("rst_stall", bus.Stall, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_edge_op", bus.EXEOpCode, 6'h00);
    chk("rst_edge_fn", bus.EXEFunction, 6'h15);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI r4 = r3 + 5
    set_id(1'b1, 6'h08, 6'h00, 6'd3, 6'd0, 6'd4, 1'b1, 1'b0,
           1'b1, 32'hA, 32'hB, 32'h5, 1'b0, 1'b0);
    tick();
    chk("addi_rd", bus.EXERd, 6'd4);
    chk("addi_imm", bus.EXEImm, 32'h5);

    // LW r7 then ADD reading r7 through Rs2
    load(6'd7);
    set_id(1'b1, 6'h00, 6'h20, 6'd1, 6'd7, 6'd8, 1'b1, 1'b1,
           1'b0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0);
    #1 chk("lu_stall", bus.Stall, 1'b1);
    tick();
    chk("lu_bubble_fn", bus.EXEFunction, 6'h15);
    tick();
    chk("lu_add_fn", bus.EXEFunction, 6'h20);
    chk("lu_cnt", bus.StallCount, 8'd1);

    // Rs2 matches but is not read
    load(6'd7);
    set_id(1'b1, 6'h08, 6'h00, 6'd1, 6'd7, 6'd9, 1'b1, 1'b0,
           1'b1, 32'h3, 32'h0, 32'h6, 1'b0, 1'b0);
    tick();
    chk("unused_op", bus.EXEOpCode, 6'h08);
    chk("unused_cnt", bus.StallCount, 8'd1);

    // Flush beats detect
    load(6'd2);
    saved = m_cnt;
    set_id(1'b1, 6'h00, 6'h20, 6'd2, 6'd0, 6'd5, 1'b1, 1'b0,
           1'b0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1);
    tick();
    chk("flush_op", bus.EXEOpCode, 6'h00);
    chk("flush_cnt", bus.StallCount, saved);

    // Hold freezes through a detect
    load(6'd5);
    set_id(1'b1, 6'h00, 6'h22, 6'd5, 6'd0, 6'd6, 1'b1, 1'b0,
           1'b0, 32'h7, 32'h8, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("hold_op", bus.EXEOpCode, 6'h23);
    chk("hold_rd", bus.EXERd, 6'd5);
    bus.Hold = 1'b0;
    tick();
    chk("hold_rel_cnt", bus.StallCount, 8'd2);

    // Reset while a stall is being signalled
    load(6'd9);
    set_id(1'b1, 6'h00, 6'h20, 6'd0, 6'd9, 6'd1, 1'b0, 1'b1,
           1'b0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0);
    #1 chk("mid_stall", bus.Stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", bus.Stall, 1'b0);
    chk("mid_rst_exe", obs_ex(), bub());
    chk("mid_rst_cnt", bus.StallCount, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ex  = bub();
    m_cnt = '0;

    // Drive the counter to saturation, then one more stall
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      load(6'd7);
      set_id(1'b1, 6'h00, 6'h20, 6'd7, 6'd0, 6'd8, 1'b1,
             1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    chk("sat_cnt", bus.StallCount, 8'hFF);
    load(6'd3);
    set_id(1'b1, 6'h23, 6'h00, 6'd3, 6'd0, 6'd4, 1'b1, 1'b0,
           1'b1, 32'h0, 32'h0, 32'h8, 1'b0, 1'b0);
    tick();
    chk("sat_hold_cnt", bus.StallCount, 8'hFF);

    // Random traffic over a small register space
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rop = 6'h23;
        1: rop = 6'h20 + 6'($urandom_range(0, 7));
        2: rop = 6'h08;
        default: rop = 6'($urandom);
      endcase
      set_id($urandom_range(0, 9) != 0, rop,
             6'($urandom),
             6'($urandom_range(0, 3)),
             6'($urandom_range(0, 3)),
             6'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
- ID/EXE pipeline register for the DLX-style pipeline. It also holds the load-use interlock.
- It captures decoded fields and register operands from ID and presents them to EXE and to the EXE forwarding unit (EXERs1, EXERs2, EXEALUSrc).
- Loads (opcodes 0x20-0x27) are not forwardable from MEM. A consumer directly behind a load therefore gets one bubble inserted, and IF/ID is stalled.
- Handles branch flush, global hold, and a saturating stall counter.

Parameters:
- DATA_W, 32, width of operand and immediate buses.
- REG_W, 6, width of register specifiers.
- CNT_W, 16, width of the stall performance counter.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- IDValid  in  1  ID holds a real instruction.
- IDOpCode  in  6  decoded opcode.
- IDFunction  in  6  R-type function field.
- IDRs1, IDRs2, IDRd  in  REG_W each  source and destination specifiers.
- IDUsesRs1, IDUsesRs2  in  1 each  decoder says the source is actually read.
- IDALUSrc  in  1  B operand is the immediate.
- IDA, IDB, IDImm  in  DATA_W each  register-file operands and extended immediate.
- Hold  in  1  global freeze (memory wait).
- Flush  in  1  branch/jump redirect resolved in EXE.
- EXEOpCode, EXEFunction  out  6 each  latched opcode and function.
- EXERs1, EXERs2, EXERd  out  REG_W each  latched specifiers.
- EXEALUSrc  out  1  latched ALUSrc.
- EXEA, EXEB, EXEImm  out  DATA_W each  latched operands.
- Stall  out  1  combinational; hold PC and IF/ID this cycle.
- StallCount  out  CNT_W  registered count of load-use bubbles.

Behaviour:
- Bubble encoding: OpCode 0x00, Function 0x15 (NOP), Rs1/Rs2/Rd 0, ALUSrc 0, A/B/Imm 0. The forwarding unit treats a bubble as non-forwardable.
- Reset: while Rst_n = 0, all EXE* outputs take the bubble value, StallCount = 0 and Stall = 0, regardless of Clk.
- Load-use detect (combinational) fires when all of the following hold:
  - EXEOpCode is in 0x20..0x27;
  - IDValid = 1;
  - (IDUsesRs1 and IDRs1 == EXERd) or (IDUsesRs2 and IDRs2 == EXERd).
  - Register 0 is not excluded.
- Stall = detect and !Flush and !Hold.
- Next-state priority on each edge (first match wins):
  1. Hold = 1: EXE register and StallCount keep their values.
  2. Flush = 1: load the bubble. The ID instruction is squashed, so no stall and no count.
  3. Detect = 1: load the bubble. The ID instruction is kept upstream by Stall. StallCount += 1, saturating at 2^CNT_W-1.
  4. IDValid = 0: load the bubble.
  5. Otherwise: capture all ID fields.
- Latency: one cycle from ID inputs to EXE outputs.
- After a load-use bubble the EXE register holds a bubble, so detect clears automatically. The stall is exactly one cycle per load/consumer pair. The load then sits in WB when the consumer reaches EXE, and the WB forward path covers it.
- Back-to-back loads: a load consuming the previous load's Rd stalls one cycle like any consumer. The second load then becomes the EXE load for the next comparison.
- Flush and detect in the same cycle: Flush wins. Stall = 0 and the counter is unchanged.
- Hold with Flush or detect: nothing changes and Stall = 0. Upstream keeps Flush asserted until Hold drops.
- Reset asserted mid-stall: bubble immediately. There is no pending-stall state, so none survives reset.

Decomposition:
- Shared package dlx_pkg:
  - constants OP_RTYPE=0x00, FN_NOP=0x15, OP_LOAD_LO=0x20, OP_LOAD_HI=0x27;
  - the bubble field values;
  - is_load(opcode) helper.
- One sub-module, load_use_detect: purely combinational detect from EXE opcode/Rd and ID sources/uses/valid.
- The register and counter stay in id_exe_stage.

Test Plan:
- Reset: drive Rst_n=0 mid-cycle with IDValid=1 and OpCode 0x08 -> outputs show bubble (OpCode 0, Function 0x15) immediately; StallCount=0.
- Plain capture: ADDI (0x08, Rs1=3, Rd=4, Imm=5, ALUSrc=1) -> next edge EXE shows the same fields; Stall=0 throughout.
- Load-use: LW (0x23, Rd=7), then ADD using Rs2=7 -> Stall=1 for one cycle and a bubble enters EXE; ADD reaches EXE the following edge; StallCount=1.
- Unused source: LW Rd=7, then ADDI with Rs2=7 but IDUsesRs2=0 -> no stall; StallCount unchanged.
- Flush vs detect: LW Rd=2, consumer Rs1=2, Flush=1 same cycle -> Stall=0, bubble loaded, StallCount unchanged.
- Hold and saturation: Hold=1 for 3 cycles during a detect -> EXE frozen, Stall=0. With StallCount preloaded to 0xFFFF by repeated stalls, the next load-use keeps it at 0xFFFF.
